// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - scan codes, one-hot directions and FSM encodings for the 2048 PS/2 input stage
package game2048_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_S     = 8'h1B;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} decode_state_t;

  // Extended arrow code to its one-hot direction; zero for any other byte.
  function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
    case (code)
      SC_UP:    arrow_onehot = DIR_UP;
      SC_DOWN:  arrow_onehot = DIR_DOWN;
      SC_LEFT:  arrow_onehot = DIR_LEFT;
      SC_RIGHT: arrow_onehot = DIR_RIGHT;
      default:  arrow_onehot = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchronisers and 11-bit frame receiver
// PS2_TIMEOUT_EN adds a mid-frame idle abort after TIMEOUT_CYCLES clocks.
module ps2_rx_frame
  import game2048_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PS2_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fall;

  frame_state_t state, state_n;
  logic [2:0]   bit_cnt, bit_cnt_n;
  logic [7:0]   shift_reg, shift_n, data_byte_n;
  logic         parity_ok, parity_ok_n;
  logic         byte_valid_n, frame_err_n;
  logic         timeout_hit;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // Idle bus is high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state != F_IDLE) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= '0;
    end else if (fall || state == F_IDLE) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift_reg;
    parity_ok_n  = parity_ok;
    data_byte_n  = data_byte;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    if (timeout_hit) begin
      state_n     = F_IDLE;
      frame_err_n = 1'b1;
    end else if (fall) begin
      case (state)
        F_IDLE: if (!dat_s) begin
          state_n   = F_DATA;
          bit_cnt_n = 3'd0;
        end
        F_DATA: begin
          shift_n   = {dat_s, shift_reg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = F_PARITY;
        end
        F_PARITY: begin
          parity_ok_n = ^{shift_reg, dat_s};
          state_n     = F_STOP;
        end
        F_STOP: begin
          if (dat_s && parity_ok) begin
            byte_valid_n = 1'b1;
            data_byte_n  = shift_reg;
          end else begin
            frame_err_n = 1'b1;
          end
          state_n = F_IDLE;
        end
        default: state_n = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= F_IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_ok  <= 1'b0;
      data_byte  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_n;
      parity_ok  <= parity_ok_n;
      data_byte  <= data_byte_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 arrow/S-key decoder with auto-repeat filter and valid/ack direction
// PS2_TIMEOUT_EN enables the mid-frame timeout in ps2_rx_frame.
module ps2_direction_decoder
  import game2048_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PS2_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       dir_ack,
  output logic [3:0] direction,
  output logic       dir_valid,
  output logic       start_pulse,
  output logic       frame_err,
  output logic [7:0] scan_code
);

  // Asynchronous assert, synchronous release.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic       byte_valid;
  logic [7:0] data_byte;

  ps2_rx_frame #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PS2_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_rx (
    .clock     (clock),
    .resetn    (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(byte_valid),
    .data_byte (data_byte),
    .frame_err (frame_err)
  );

  assign scan_code = data_byte;

  decode_state_t dstate, dstate_n;
  logic [3:0]    held, held_n, hit, make_dir, direction_n;
  logic          held_s, held_s_n, dir_valid_n, start_n;

  assign hit = arrow_onehot(data_byte);

  always_comb begin
    dstate_n    = dstate;
    held_n      = held;
    held_s_n    = held_s;
    make_dir    = 4'b0000;
    start_n     = 1'b0;
    direction_n = direction;
    dir_valid_n = dir_valid;
    if (byte_valid) begin
      case (dstate)
        D_IDLE: begin
          if (data_byte == SC_EXT)      dstate_n = D_EXT;
          else if (data_byte == SC_BRK) dstate_n = D_BRK;
          else if (data_byte == SC_S && !held_s) begin
            start_n  = 1'b1;
            held_s_n = 1'b1;
          end
        end
        D_EXT: begin
          if (data_byte == SC_BRK) begin
            dstate_n = D_EXT_BRK;
          end else begin
            dstate_n = D_IDLE;
            if ((held & hit) == 4'b0000) begin
              make_dir = hit;
              held_n   = held | hit;
            end
          end
        end
        D_BRK: begin
          if (data_byte == SC_S) held_s_n = 1'b0;
          dstate_n = D_IDLE;
        end
        D_EXT_BRK: begin
          held_n   = held & ~hit;
          dstate_n = D_IDLE;
        end
        default: dstate_n = D_IDLE;
      endcase
    end
    // A fresh press lands only in an empty slot or one being consumed this cycle.
    if (make_dir != 4'b0000) begin
      if (!dir_valid || dir_ack) begin
        direction_n = make_dir;
        dir_valid_n = 1'b1;
      end
    end else if (dir_valid && dir_ack) begin
      direction_n = 4'b0000;
      dir_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dstate      <= D_IDLE;
      held        <= 4'b0000;
      held_s      <= 1'b0;
      direction   <= 4'b0000;
      dir_valid   <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      dstate      <= dstate_n;
      held        <= held_n;
      held_s      <= held_s_n;
      direction   <= direction_n;
      dir_valid   <= dir_valid_n;
      start_pulse <= start_n;
    end
  end

endmodule
